ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Consumes the registered ID/EX pipeline outputs and produces ALU result, store data, destination register and passed-through control for the EX/MEM buffer.
- Single-cycle ALU ops complete combinationally.
- MULT/MULTU/DIV/DIVU run on a 32-iteration radix-2 sequential unit that writes HI/LO. While it runs, the unit asserts exStall back to the ID/EX buffer and hazard logic.

---
 rtl/ex_stage_if.sv | 46 ++++
 rtl/ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX and EX-to-EX/MEM signal bundle for the execute stage.
// The master drives the ID/EX controls; the slave is the execute stage itself.
interface ex_stage_if;
   logic        memStall;
   logic        regWriteIn;
   logic        mem2RegIn;
   logic        memReadIn;
   logic        memWriteIn;
   logic        pc2RegIn;
   logic        regDstIn;
   logic        haltIn;
   logic [3:0]  ALUOpIn;
   logic [1:0]  ALUSrcIn;
   logic [31:0] PCIn;
   logic [31:0] data1In;
   logic [31:0] data2In;
   logic [31:0] signExtIn;
   logic [4:0]  reg2In;
   logic [4:0]  reg3In;

   logic [31:0] aluResultOut;
   logic [31:0] writeDataOut;
   logic [4:0]  destRegOut;
   logic        regWriteOut;
   logic        mem2RegOut;
   logic        memReadOut;
   logic        memWriteOut;
   logic        haltOut;
   logic [31:0] hiOut;
   logic [31:0] loOut;
   logic        exStall;

   modport master (
      output memStall, regWriteIn, mem2RegIn, memReadIn, memWriteIn, pc2RegIn, regDstIn,
             haltIn, ALUOpIn, ALUSrcIn, PCIn, data1In, data2In, signExtIn, reg2In, reg3In,
      input  aluResultOut, writeDataOut, destRegOut, regWriteOut, mem2RegOut, memReadOut,
             memWriteOut, haltOut, hiOut, loOut, exStall
   );

   modport slave (
      input  memStall, regWriteIn, mem2RegIn, memReadIn, memWriteIn, pc2RegIn, regDstIn,
             haltIn, ALUOpIn, ALUSrcIn, PCIn, data1In, data2In, signExtIn, reg2In, reg3In,
      output aluResultOut, writeDataOut, destRegOut, regWriteOut, mem2RegOut, memReadOut,
             memWriteOut, haltOut, hiOut, loOut, exStall
   );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU plus a radix-2 sequential mul/div unit
// that owns HI/LO and stalls the front of the pipeline while it iterates.
module ex_stage #(
   parameter int unsigned MD_CYCLES = 32,
   parameter logic [31:0] DIV0_LO   = 32'hFFFFFFFF
) (
   input logic        clockIn,
   input logic        reset,
   ex_stage_if.slave  bus
);

   localparam logic [4:0] LastCnt = 5'(MD_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

   // ---------------------------------------------------------------------------
   // ALU and pass-through
   // ---------------------------------------------------------------------------
   logic [31:0] alu_b;
   logic [4:0]  shamt;
   logic [31:0] alu_res;

   always_comb begin
      alu_b = '0;
      case (bus.ALUSrcIn)
         2'd0:    alu_b = bus.data2In;
         2'd1:    alu_b = bus.signExtIn;
         2'd2:    alu_b = bus.data2In;
         default: alu_b = '0;
      endcase
      shamt = (bus.ALUSrcIn == 2'd2) ? bus.signExtIn[10:6] : bus.data1In[4:0];
   end

   always_comb begin
      alu_res = '0;
      case (bus.ALUOpIn)
         4'd0:    alu_res = bus.data1In + alu_b;
         4'd1:    alu_res = bus.data1In - alu_b;
         4'd2:    alu_res = bus.data1In & alu_b;
         4'd3:    alu_res = bus.data1In | alu_b;
         4'd4:    alu_res = bus.data1In ^ alu_b;
         4'd5:    alu_res = ~(bus.data1In | alu_b);
         4'd6:    alu_res = {31'b0, $signed(bus.data1In) < $signed(alu_b)};
         4'd7:    alu_res = {31'b0, bus.data1In < alu_b};
         4'd8:    alu_res = alu_b << shamt;
         4'd9:    alu_res = alu_b >> shamt;
         4'd10:   alu_res = $unsigned($signed(alu_b) >>> shamt);
         4'd11:   alu_res = {bus.signExtIn[15:0], 16'b0};
         default: alu_res = '0;
      endcase
      // Link instructions write the return address regardless of the op field.
      if (bus.pc2RegIn) alu_res = bus.PCIn + 32'd4;
   end

   assign bus.aluResultOut = alu_res;
   assign bus.writeDataOut = bus.data2In;
   assign bus.destRegOut   = bus.pc2RegIn ? 5'd31 : (bus.regDstIn ? bus.reg3In : bus.reg2In);
   assign bus.regWriteOut  = bus.regWriteIn;
   assign bus.mem2RegOut   = bus.mem2RegIn;
   assign bus.memReadOut   = bus.memReadIn;
   assign bus.memWriteOut  = bus.memWriteIn;
   assign bus.haltOut      = bus.haltIn;

   // ---------------------------------------------------------------------------
   // Mul/div unit
   // ---------------------------------------------------------------------------
   md_state_e   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] p_q, p_d;           // mul: {acc, multiplier}; div: {rem, quotient}
   logic [31:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [31:0] dvd_q, dvd_d;       // raw dividend, returned in HI on divide-by-zero
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;       // product / quotient sign
   logic        rem_neg_q, rem_neg_d;
   logic        div0_q, div0_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        ex_stall;

   logic        md_op, op_signed, op_div, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;

   always_comb begin
      md_op     = (bus.ALUOpIn[3:2] == 2'b11);
      op_signed = ~bus.ALUOpIn[0];
      op_div    = bus.ALUOpIn[1];
      a_neg     = op_signed & bus.data1In[31];
      b_neg     = op_signed & bus.data2In[31];
      a_mag     = a_neg ? (32'd0 - bus.data1In) : bus.data1In;
      b_mag     = b_neg ? (32'd0 - bus.data2In) : bus.data2In;
   end

   logic [32:0] mul_sum, div_cand, div_diff;
   logic [63:0] iter_next, prod_fix;
   logic [31:0] quo_fix, rem_fix;

   always_comb begin
      mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, opnd_q} : 33'd0);
      div_cand = {p_q[63:32], p_q[31]};
      div_diff = div_cand - {1'b0, opnd_q};
      if (is_div_q) begin
         // Restoring step: a borrow means the divisor did not fit this round.
         iter_next = div_diff[32] ? {div_cand[31:0], p_q[30:0], 1'b0}
                                  : {div_diff[31:0], p_q[30:0], 1'b1};
      end else begin
         iter_next = {mul_sum, p_q[31:1]};
      end
      prod_fix = neg_q ? (64'd0 - iter_next) : iter_next;
      quo_fix  = neg_q ? (32'd0 - iter_next[31:0]) : iter_next[31:0];
      rem_fix  = rem_neg_q ? (32'd0 - iter_next[63:32]) : iter_next[63:32];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      p_d       = p_q;
      opnd_d    = opnd_q;
      dvd_d     = dvd_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      ex_stall  = 1'b0;
      case (state_q)
         StIdle: begin
            if (md_op) begin
               ex_stall  = 1'b1;
               state_d   = StBusy;
               cnt_d     = '0;
               p_d       = {32'd0, op_div ? a_mag : b_mag};
               opnd_d    = op_div ? b_mag : a_mag;
               dvd_d     = bus.data1In;
               is_div_d  = op_div;
               neg_d     = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               div0_d    = op_div && (bus.data2In == 32'd0);
            end
         end
         StBusy: begin
            ex_stall = 1'b1;
            p_d      = iter_next;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               cnt_d   = '0;
               if (!is_div_q) begin
                  hi_d = prod_fix[63:32];
                  lo_d = prod_fix[31:0];
               end else if (div0_q) begin
                  hi_d = dvd_q;
                  lo_d = DIV0_LO;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         StDone: begin
            if (!bus.memStall) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (reset) ex_stall = 1'b0;
   end

   always_ff @(posedge clockIn) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         p_q       <= '0;
         opnd_q    <= '0;
         dvd_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         p_q       <= p_d;
         opnd_q    <= opnd_d;
         dvd_q     <= dvd_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.hiOut   = hi_q;
   assign bus.loOut   = lo_q;
   assign bus.exStall = ex_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vectors, link/destination muxing, and
// mul/div timing, results, memStall hold in DONE and mid-operation reset.
module tb_ex_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_eval = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ex_stage_if u_if ();

   ex_stage #(
      .MD_CYCLES (32),
      .DIV0_LO   (32'hFFFFFFFF)
   ) u_dut (
      .clockIn (clk),
      .reset   (rst),
      .bus     (u_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_eval++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues a mul/div op right after an edge; returns in the first non-stalled cycle.
   task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int start);
      @(posedge clk);
      #1;
      u_if.ALUOpIn  = op;
      u_if.ALUSrcIn = 2'd0;
      u_if.pc2RegIn = 1'b0;
      u_if.data1In  = a;
      u_if.data2In  = b;
      start  = cyc;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (u_if.exStall) stalls++;
         else break;
      end
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      u_if.ALUOpIn = 4'd0;
   endtask

   int s1, t1, s2, t2;
   logic [31:0] hold_hi, hold_lo;

   initial begin
      u_if.memStall   = 1'b0;
      u_if.regWriteIn = 1'b0;
      u_if.mem2RegIn  = 1'b0;
      u_if.memReadIn  = 1'b0;
      u_if.memWriteIn = 1'b0;
      u_if.pc2RegIn   = 1'b0;
      u_if.regDstIn   = 1'b0;
      u_if.haltIn     = 1'b0;
      u_if.ALUOpIn    = 4'd12;
      u_if.ALUSrcIn   = 2'd0;
      u_if.PCIn       = '0;
      u_if.data1In    = 32'd3;
      u_if.data2In    = 32'd4;
      u_if.signExtIn  = '0;
      u_if.reg2In     = 5'd2;
      u_if.reg3In     = 5'd3;

      // Reset held with a mul op present: no stall, HI/LO cleared
      #2;
      chk("rst_stall", {31'b0, u_if.exStall}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      u_if.ALUOpIn = 4'd0;
      #1;
      chk("rst_hi", u_if.hiOut, 32'd0);
      chk("rst_lo", u_if.loOut, 32'd0);

      // ALU vectors
      u_if.data1In = 32'h7FFFFFFF; u_if.data2In = 32'd1; u_if.ALUOpIn = 4'd0;
      #1;
      chk("add", u_if.aluResultOut, 32'h80000000);
      chk("add_stall", {31'b0, u_if.exStall}, 32'd0);
      chk("wdata", u_if.writeDataOut, 32'd1);
      u_if.data1In = 32'd5; u_if.signExtIn = 32'hFFFFFFFF; u_if.ALUSrcIn = 2'd1;
      #1;
      chk("addi", u_if.aluResultOut, 32'd4);
      u_if.data2In = 32'h80000010; u_if.signExtIn = 32'h00000100;
      u_if.ALUSrcIn = 2'd2; u_if.ALUOpIn = 4'd10;
      #1;
      chk("sra", u_if.aluResultOut, 32'hF8000001);
      u_if.data1In = 32'd3; u_if.data2In = 32'd1; u_if.ALUSrcIn = 2'd0; u_if.ALUOpIn = 4'd8;
      #1;
      chk("sllv", u_if.aluResultOut, 32'd8);
      u_if.data1In = 32'hFFFFFFFF; u_if.ALUOpIn = 4'd6;
      #1;
      chk("slt", u_if.aluResultOut, 32'd1);
      u_if.ALUOpIn = 4'd7;
      #1;
      chk("sltu", u_if.aluResultOut, 32'd0);
      u_if.signExtIn = 32'h00001234; u_if.ALUOpIn = 4'd11;
      #1;
      chk("lui", u_if.aluResultOut, 32'h12340000);

      // Link and destination select
      u_if.pc2RegIn = 1'b1; u_if.PCIn = 32'h00400008; u_if.regDstIn = 1'b1; u_if.reg3In = 5'd9;
      #1;
      chk("link_res", u_if.aluResultOut, 32'h0040000C);
      chk("link_dst", {27'b0, u_if.destRegOut}, 32'd31);
      u_if.pc2RegIn = 1'b0;
      #1;
      chk("rd_dst", {27'b0, u_if.destRegOut}, 32'd9);
      u_if.regDstIn = 1'b0;
      #1;
      chk("rt_dst", {27'b0, u_if.destRegOut}, 32'd2);
      u_if.regWriteIn = 1'b1; u_if.memWriteIn = 1'b1; u_if.haltIn = 1'b1;
      #1;
      chk("ctl", {27'b0, u_if.regWriteOut, u_if.mem2RegOut, u_if.memReadOut,
                  u_if.memWriteOut, u_if.haltOut}, 32'h13);

      // MULT -3 * 7
      run_md(4'd12, 32'hFFFFFFFD, 32'd7, s1, t1);
      chk("mult_stall", 32'(s1), 32'd33);
      chk("mult_hi", u_if.hiOut, 32'hFFFFFFFF);
      chk("mult_lo", u_if.loOut, 32'hFFFFFFEB);
      chk("md_res0", u_if.aluResultOut, 32'd0);
      go_idle();

      // MULTU 0xFFFFFFFF squared
      run_md(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, s1, t1);
      chk("multu_stall", 32'(s1), 32'd33);
      chk("multu_hi", u_if.hiOut, 32'hFFFFFFFE);
      chk("multu_lo", u_if.loOut, 32'd1);
      go_idle();

      // DIV -7 / 2
      run_md(4'd14, 32'hFFFFFFF9, 32'd2, s1, t1);
      chk("div_stall", 32'(s1), 32'd33);
      chk("div_lo", u_if.loOut, 32'hFFFFFFFD);
      chk("div_hi", u_if.hiOut, 32'hFFFFFFFF);
      go_idle();

      // DIV 0x80000000 / -1, then memStall held through DONE
      run_md(4'd14, 32'h80000000, 32'hFFFFFFFF, s1, t1);
      chk("ovf_lo", u_if.loOut, 32'h80000000);
      chk("ovf_hi", u_if.hiOut, 32'd0);
      hold_hi = u_if.hiOut;
      hold_lo = u_if.loOut;
      u_if.memStall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_stall", {31'b0, u_if.exStall}, 32'd0);
         chk("hold_hi", u_if.hiOut, hold_hi);
         chk("hold_lo", u_if.loOut, hold_lo);
      end
      u_if.memStall = 1'b0;
      go_idle();
      @(negedge clk);
      chk("rel_stall", {31'b0, u_if.exStall}, 32'd0);
      chk("rel_lo", u_if.loOut, 32'h80000000);

      // Reset in BUSY iteration 10 aborts the divide
      @(posedge clk);
      #1;
      u_if.ALUOpIn = 4'd15; u_if.data1In = 32'd100; u_if.data2In = 32'd3;
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_stall", {31'b0, u_if.exStall}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      u_if.ALUOpIn = 4'd0;
      #1;
      chk("abort_hi", u_if.hiOut, 32'd0);
      chk("abort_lo", u_if.loOut, 32'd0);
      chk("abort_idle", {31'b0, u_if.exStall}, 32'd0);

      // DIVU by zero from a fresh IDLE
      run_md(4'd15, 32'd7, 32'd0, s1, t1);
      chk("div0_stall", 32'(s1), 32'd33);
      chk("div0_lo", u_if.loOut, 32'hFFFFFFFF);
      chk("div0_hi", u_if.hiOut, 32'd7);

      // Back-to-back MULTs: second issues on the edge leaving DONE
      go_idle();
      run_md(4'd12, 32'd6, 32'd7, s1, t1);
      chk("b2b1_lo", u_if.loOut, 32'd42);
      run_md(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, s2, t2);
      chk("b2b_gap", 32'(t2 - t1), 32'd34);
      chk("b2b2_stall", 32'(s2), 32'd33);
      chk("b2b2_hi", u_if.hiOut, 32'd0);
      chk("b2b2_lo", u_if.loOut, 32'd1);
      go_idle();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule
